// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the decoder/register-file side and the ALU execution unit.
// The master issues a start with operands; the slave reports busy/done, result and NZCV flags.
interface alu_exec_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [3:0]         alu_control;
    logic [1:0]         flag_w;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               result_we;
    logic               illegal;
    logic [3:0]         flags;

    modport master (
        output start, alu_control, flag_w, src_a, src_b, shamt,
        input  busy, done, result, result_we, illegal, flags
    );

    modport slave (
        input  start, alu_control, flag_w, src_a, src_b, shamt,
        output busy, done, result, result_we, illegal, flags
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit with NZCV register: single-cycle arith/logic, iterative shifts (SHIFT_STEP bits/cycle).
// done arrives 1 cycle after start (shifts: 1 + ceil(shamt/SHIFT_STEP)); start is ignored while busy, nothing queues.
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int SHIFT_STEP = 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_LSL = 4'b0111;
    localparam logic [3:0] OP_LSR = 4'b1000;
    localparam logic [3:0] OP_ASR = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1011;

    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op inside {OP_LSL, OP_LSR, OP_ASR, OP_ROR};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR, OP_NOT,
                          OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_CMP};
    endfunction

    state_t             state, state_n;
    logic [WIDTH-1:0]   result_q, result_n;
    logic [WIDTH-1:0]   sreg, sreg_n;
    logic [3:0]         flags_q, flags_n;
    logic [3:0]         op_q, op_n;
    logic [1:0]         fw_q, fw_n;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic               we_q, we_n, ill_q, ill_n;

    logic [SHAMT_W:0]   k;
    logic [WIDTH:0]     ext_l, ext_r, ext_a;
    logic [WIDTH-1:0]   rot;
    logic [WIDTH-1:0]   step_res;
    logic               step_c;
    logic [WIDTH:0]     sum, diff;
    logic               upd, upd_nz, upd_c, upd_v, c_val, v_val;
    logic [WIDTH-1:0]   upd_res;
    logic [3:0]         upd_op;

    // One shift step; the extra bit on each side of the operand catches the last bit shifted out.
    always_comb begin
        k        = ({1'b0, cnt} > STEP_C) ? STEP_C : {1'b0, cnt};
        ext_l    = {1'b0, sreg} << k;
        ext_r    = {sreg, 1'b0} >> k;
        ext_a    = $signed({sreg, 1'b0}) >>> k;
        rot      = WIDTH'({sreg, sreg} >> k);
        step_res = ext_l[WIDTH-1:0];
        step_c   = ext_l[WIDTH];
        case (op_q)
            OP_LSR:  begin step_res = ext_r[WIDTH:1]; step_c = ext_r[0];       end
            OP_ASR:  begin step_res = ext_a[WIDTH:1]; step_c = ext_a[0];       end
            OP_ROR:  begin step_res = rot;            step_c = rot[WIDTH-1];   end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        result_n = result_q;
        flags_n  = flags_q;
        cnt_n    = cnt;
        sreg_n   = sreg;
        op_n     = op_q;
        fw_n     = fw_q;
        we_n     = we_q;
        ill_n    = ill_q;
        upd      = 1'b0;
        upd_res  = '0;
        upd_op   = op_q;
        upd_nz   = 1'b0;
        upd_c    = 1'b0;
        upd_v    = 1'b0;
        c_val    = 1'b0;
        v_val    = 1'b0;
        sum      = {1'b0, bus.src_a} + {1'b0, bus.src_b};
        diff     = {1'b0, bus.src_a} - {1'b0, bus.src_b};

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_shift(bus.alu_control) && bus.shamt != '0) begin
                        sreg_n  = bus.src_b;
                        cnt_n   = bus.shamt;
                        op_n    = bus.alu_control;
                        fw_n    = bus.flag_w;
                        state_n = SHIFT;
                    end else begin
                        upd     = 1'b1;
                        upd_op  = bus.alu_control;
                        upd_nz  = bus.flag_w[1];
                        state_n = DONE;
                        case (bus.alu_control)
                            OP_ADD: begin
                                upd_res = sum[WIDTH-1:0];
                                c_val   = sum[WIDTH];
                                v_val   = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                                          (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
                                upd_c   = bus.flag_w[0];
                                upd_v   = bus.flag_w[0];
                            end
                            OP_SUB, OP_CMP: begin
                                upd_res = diff[WIDTH-1:0];
                                c_val   = ~diff[WIDTH];
                                v_val   = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                                          (diff[WIDTH-1] != bus.src_a[WIDTH-1]);
                                upd_c   = bus.flag_w[0];
                                upd_v   = bus.flag_w[0];
                            end
                            OP_AND: upd_res = bus.src_a & bus.src_b;
                            OP_ORR: upd_res = bus.src_a | bus.src_b;
                            OP_XOR: upd_res = bus.src_a ^ bus.src_b;
                            OP_NOT: upd_res = ~bus.src_b;
                            // Zero-distance shift passes src_b through and leaves C alone.
                            OP_LSL, OP_LSR, OP_ASR, OP_ROR: upd_res = bus.src_b;
                            default: begin
                                upd_res = '0;
                                upd_nz  = 1'b0;
                            end
                        endcase
                    end
                end
            end
            SHIFT: begin
                cnt_n  = cnt - k[SHAMT_W-1:0];
                sreg_n = step_res;
                if (cnt_n == '0) begin
                    upd     = 1'b1;
                    upd_res = step_res;
                    upd_nz  = fw_q[1];
                    upd_c   = fw_q[0];
                    c_val   = step_c;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (upd) begin
            result_n = upd_res;
            if (upd_nz) begin
                flags_n[3] = upd_res[WIDTH-1];
                flags_n[2] = (upd_res == '0);
            end
            if (upd_c) flags_n[1] = c_val;
            if (upd_v) flags_n[0] = v_val;
            ill_n = !is_legal(upd_op);
            we_n  = is_legal(upd_op) && (upd_op != OP_CMP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            cnt      <= '0;
            sreg     <= '0;
            op_q     <= '0;
            fw_q     <= '0;
            we_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state    <= state_n;
            result_q <= result_n;
            flags_q  <= flags_n;
            cnt      <= cnt_n;
            sreg     <= sreg_n;
            op_q     <= op_n;
            fw_q     <= fw_n;
            we_q     <= we_n;
            ill_q    <= ill_n;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.result_we = bus.done & we_q;
    assign bus.illegal   = bus.done & ill_q;
    assign bus.flags     = flags_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, multi-cycle ALU execution unit that consumes the 4-bit ALU control code and 2-bit flag-write mask from the ALU decoder.
- Computes the result and NZCV flags, and holds the NZCV flag register.
- Arithmetic and logical ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, behind a start/busy/done handshake.
- Sits between the decoder/register file and the result-writeback mux of the ARMv4 datapath.

Parameters:
WIDTH, 32, datapath width in bits (>=8).
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
SHIFT_STEP, 1, maximum bits shifted per SHIFT cycle (1..WIDTH).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
alu_control  in  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 XOR, 0101 NOT, 0111 LSL, 1000 LSR, 1001 ASR, 1010 ROR, 1011 CMP; all other codes are illegal.
flag_w  in  2  [1] write N,Z; [0] write C,V (per-op rules below).
src_a  in  WIDTH  operand A.
src_b  in  WIDTH  operand B; also the shift source.
shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse; result and flags are valid in this cycle.
result  out  WIDTH  registered result; holds its value until the next done.
result_we  out  1  done & legal & op != CMP.
illegal  out  1  pulses with done when alu_control is undefined.
flags  out  4  NZCV register {N,Z,C,V}.

Behaviour:
- Reset (async, any state): state=IDLE; result=0; flags=0000; done=0; result_we=0; illegal=0; busy=0; shift counter=0. Reset mid-operation discards the operation and performs no flag update.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE & start & non-shift op: result and flags are registered from the inputs at this edge; next state DONE. Latency: done is high in the cycle after start.
  - IDLE & start & shift op & shamt=0: result=src_b; next state DONE; C unchanged.
  - IDLE & start & shift op & shamt>0: latch src_b, op, flag_w; count=shamt; next state SHIFT.
  - SHIFT: each cycle, shift by k=min(SHIFT_STEP,count), then count-=k. When count reaches 0, register result and flags and go to DONE. SHIFT occupancy is ceil(shamt/SHIFT_STEP) cycles.
  - DONE: done=1, then unconditionally return to IDLE. start is ignored in SHIFT and DONE (no queuing). Back-to-back throughput for single-cycle ops is one op per 2 cycles.
- Arithmetic, all results mod 2^WIDTH:
  - ADD: C = carry out of the MSB; V = signed overflow.
  - SUB/CMP: A-B; C = 1 when A>=B unsigned (no borrow); V = signed overflow.
- Logical ops AND/ORR/XOR: A op B. NOT = ~B.
- Shifts on src_b:
  - LSL and LSR zero-fill; ASR fills with the sign of src_b; ROR rotates.
  - C = last bit shifted out. For ROR, C = result[WIDTH-1].
- Flag writes, applied on the edge entering DONE:
  - N = result[WIDTH-1], Z = (result==0), each written only if flag_w[1].
  - flag_w[0] writes C and V for ADD/SUB/CMP. For shifts it writes C only; V is unchanged. For AND/ORR/XOR/NOT it has no effect.
- CMP: flags are updated as for SUB and result is registered, but result_we=0.
- Illegal code: result=0, flags unchanged, done pulses with illegal=1, result_we=0.
- Operand and control inputs are not sampled after the start edge; changing them during SHIFT has no effect.

Test Plan:
1. WIDTH=32. ADD 0x7FFFFFFF+0x00000001, flag_w=11 -> done 1 cycle after start; result=0x80000000; NZCV=1001; result_we=1.
2. CMP 5,5, flag_w=11 -> result_we=0; NZCV=0110. Then SUB 3-5, flag_w=00 -> result=0xFFFFFFFE; NZCV stays 0110.
3. STEP=1. ASR src_b=0x80000000, shamt=4, flag_w=11 -> busy for 5 cycles; done 5 cycles after start; result=0xF8000000; N=1, C=0, V unchanged.
4. Set C=1 via an ADD carry (0xFFFFFFFF+1). Then LSL shamt=0, src_b=0x1234, flag_w=11 -> done after 1 cycle; result=0x1234; C stays 1.
5. STEP=4. ROR src_b=0x0000000F, shamt=4 -> 1 SHIFT cycle; done 2 cycles after start; result=0xF0000000; C=1 (flag_w=01).
6. start pulsed during SHIFT -> ignored. Assert reset mid-SHIFT of an LSR -> immediate IDLE; flags=0000; no done; a following AND then completes normally. alu_control=0110 -> illegal=1 and done=1; flags unchanged.
